// File: rtl/memory_controller.sv
// memory_controller: byte-serial bridge between the load/store buffer (LSB),
// the instruction-fetch unit (IF) and the 8-bit unified RAM/IO bus.
// One word/halfword/byte request is served at a time. Loads are assembled
// little-endian and sign/zero-extended. Stores are written byte by byte.
// The LSB has priority over fetch. A misprediction clear aborts reads only.
//
// Ports
//   clk_in, rst_in (async, active-low), rdy_in (global pause)
//   clear_signal                    misprediction flush
//   lsb_signal/wr/signed/len/addr/dout -> lsb_din, lsb_done
//   if_signal/if_addr               -> if_din, if_done
//   mem_din                         -> mem_dout, mem_a, mem_wr
//   io_buffer_full                  IO write back-pressure
module memory_controller #(
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear_signal,
    input  logic        lsb_signal,
    input  logic        lsb_wr,
    input  logic        lsb_signed,
    input  logic [1:0]  lsb_len,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_dout,
    output logic [31:0] lsb_din,
    output logic        lsb_done,
    input  logic        if_signal,
    input  logic [31:0] if_addr,
    output logic [31:0] if_din,
    output logic        if_done,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 8;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic            owner_lsb, owner_lsb_d;
    logic [AW-1:0]   req_addr, req_addr_d;
    logic [DW-1:0]   req_data, req_data_d;
    logic [CW-1:0]   req_len, req_len_d;
    logic            req_signed, req_signed_d;
    logic [DW-1:0]   rd_word, rd_word_d;
    logic [AW-1:0]   mem_a_d;
    logic [BW-1:0]   mem_dout_d;
    logic            mem_wr_q, mem_wr_d;
    logic [DW-1:0]   lsb_din_d, if_din_d;
    logic            lsb_done_d, if_done_d;

    logic            io_stall;
    logic [AW-1:0]   next_addr;
    logic [BW-1:0]   next_byte;
    logic [DW-1:0]   merged;

    // Byte count of a request: 10 is treated as a full word.
    function automatic logic [CW-1:0] decode_len(input logic [1:0] len);
        case (len)
            2'b00:   return CW'(1);
            2'b01:   return CW'(2);
            default: return CW'(4);
        endcase
    endfunction

    // Sign- or zero-extend the assembled load to 32 bits.
    function automatic logic [DW-1:0] extend(input logic [DW-1:0] w,
                                             input logic [CW-1:0] n,
                                             input logic          sgn);
        case (n)
            CW'(1):  return sgn ? {{24{w[7]}}, w[7:0]}   : {24'h0, w[7:0]};
            CW'(2):  return sgn ? {{16{w[15]}}, w[15:0]} : {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    // A write to IO space is held off while the IO buffer is full.
    assign io_stall  = io_buffer_full && (mem_a[17:16] == IO_SEL);
    assign mem_wr    = mem_wr_q && rdy_in && !io_stall;

    assign next_addr = req_addr + AW'(cnt) + AW'(1);
    assign next_byte = BW'(req_data >> {cnt + CW'(1), 3'b000});

    // The byte on mem_din belongs to the address presented one edge earlier.
    always_comb begin
        merged = rd_word;
        case (cnt)
            CW'(1):  merged[7:0]   = mem_din;
            CW'(2):  merged[15:8]  = mem_din;
            CW'(3):  merged[23:16] = mem_din;
            CW'(4):  merged[31:24] = mem_din;
            default: ;
        endcase
    end

    // Next-state and register-input logic; everything holds while rdy_in is low.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        owner_lsb_d  = owner_lsb;
        req_addr_d   = req_addr;
        req_data_d   = req_data;
        req_len_d    = req_len;
        req_signed_d = req_signed;
        rd_word_d    = rd_word;
        mem_a_d      = mem_a;
        mem_dout_d   = mem_dout;
        mem_wr_d     = mem_wr_q;
        lsb_din_d    = lsb_din;
        if_din_d     = if_din;
        lsb_done_d   = lsb_done;
        if_done_d    = if_done;

        if (rdy_in) begin
            case (state)
                ST_IDLE: begin
                    if (lsb_signal) begin
                        owner_lsb_d  = 1'b1;
                        req_addr_d   = lsb_addr;
                        req_data_d   = lsb_dout;
                        req_len_d    = decode_len(lsb_len);
                        req_signed_d = lsb_signed;
                        rd_word_d    = '0;
                        mem_a_d      = lsb_addr;
                        cnt_d        = '0;
                        if (lsb_wr) begin
                            mem_dout_d = lsb_dout[7:0];
                            mem_wr_d   = 1'b1;
                            state_d    = ST_WRITE;
                        end else begin
                            mem_wr_d   = 1'b0;
                            state_d    = ST_READ;
                        end
                    end else if (if_signal) begin
                        owner_lsb_d  = 1'b0;
                        req_addr_d   = if_addr;
                        req_data_d   = '0;
                        req_len_d    = CW'(4);
                        req_signed_d = 1'b0;
                        rd_word_d    = '0;
                        mem_a_d      = if_addr;
                        cnt_d        = '0;
                        mem_wr_d     = 1'b0;
                        state_d      = ST_READ;
                    end
                end

                ST_READ: begin
                    if (clear_signal) begin
                        // Abort wins even over a completing read.
                        mem_wr_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        rd_word_d = merged;
                        if (cnt < req_len - CW'(1)) begin
                            mem_a_d = next_addr;
                        end
                        if (cnt == req_len) begin
                            if (owner_lsb) begin
                                lsb_din_d  = extend(merged, req_len, req_signed);
                                lsb_done_d = 1'b1;
                            end else begin
                                if_din_d   = merged;
                                if_done_d  = 1'b1;
                            end
                            state_d = ST_DONE;
                        end else begin
                            cnt_d = cnt + CW'(1);
                        end
                    end
                end

                ST_WRITE: begin
                    // Stores ignore clear; a stalled byte is simply re-driven.
                    if (!io_stall) begin
                        if (cnt == req_len - CW'(1)) begin
                            mem_wr_d   = 1'b0;
                            lsb_done_d = 1'b1;
                            state_d    = ST_DONE;
                        end else begin
                            mem_a_d    = next_addr;
                            mem_dout_d = next_byte;
                            cnt_d      = cnt + CW'(1);
                        end
                    end
                end

                ST_DONE: begin
                    // Cool-down cycle so the requester can drop its signal.
                    lsb_done_d = 1'b0;
                    if_done_d  = 1'b0;
                    state_d    = ST_IDLE;
                end

                default: begin
                    mem_wr_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            owner_lsb  <= 1'b0;
            req_addr   <= '0;
            req_data   <= '0;
            req_len    <= '0;
            req_signed <= 1'b0;
            rd_word    <= '0;
            mem_a      <= '0;
            mem_dout   <= '0;
            mem_wr_q   <= 1'b0;
            lsb_din    <= '0;
            if_din     <= '0;
            lsb_done   <= 1'b0;
            if_done    <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            owner_lsb  <= owner_lsb_d;
            req_addr   <= req_addr_d;
            req_data   <= req_data_d;
            req_len    <= req_len_d;
            req_signed <= req_signed_d;
            rd_word    <= rd_word_d;
            mem_a      <= mem_a_d;
            mem_dout   <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            lsb_din    <= lsb_din_d;
            if_din     <= if_din_d;
            lsb_done   <= lsb_done_d;
            if_done    <= if_done_d;
        end
    end

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller with a one-cycle-latency RAM model.
module tb_memory_controller;

    logic        clk = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        clear_signal = 1'b0;
    logic        lsb_signal = 1'b0;
    logic        lsb_wr = 1'b0;
    logic        lsb_signed = 1'b0;
    logic [1:0]  lsb_len = 2'b00;
    logic [31:0] lsb_addr = '0;
    logic [31:0] lsb_dout = '0;
    logic [31:0] lsb_din;
    logic        lsb_done;
    logic        if_signal = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_din;
    logic        if_done;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int e0 = 0;

    logic [7:0]  ram [0:4095];
    logic [31:0] wa [0:15];
    logic [7:0]  wd [0:15];
    int          wc [0:15];
    int          wn = 0;

    memory_controller dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .clear_signal   (clear_signal),
        .lsb_signal     (lsb_signal),
        .lsb_wr         (lsb_wr),
        .lsb_signed     (lsb_signed),
        .lsb_len        (lsb_len),
        .lsb_addr       (lsb_addr),
        .lsb_dout       (lsb_dout),
        .lsb_din        (lsb_din),
        .lsb_done       (lsb_done),
        .if_signal      (if_signal),
        .if_addr        (if_addr),
        .if_din         (if_din),
        .if_done        (if_done),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM: byte addressed in cycle t is returned in cycle t+1; the bus is
    // paused together with the core while rdy_in is low.
    always @(posedge clk) begin
        if (rdy_in) begin
            mem_din <= ram[mem_a[11:0]];
            if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
        end
    end

    // Log every bus write.
    always @(posedge clk) begin
        if (mem_wr && wn < 16) begin
            wa[wn] = mem_a;
            wd[wn] = mem_dout;
            wc[wn] = cyc;
            wn = wn + 1;
        end
    end

    task automatic issue(input logic wr, input logic sgn, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        lsb_wr     = wr;
        lsb_signed = sgn;
        lsb_len    = len;
        lsb_addr   = addr;
        lsb_dout   = data;
        lsb_signal = 1'b1;
        e0 = cyc + 1;
    endtask

    // Bounded wait for lsb_done; returns the edge number or -1 on timeout.
    task automatic wait_lsb(output int edge_no, output logic [31:0] d);
        edge_no = -1;
        d = 32'hDEAD_BEEF;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (lsb_done) begin
                edge_no = cyc;
                d = lsb_din;
                break;
            end
        end
        lsb_signal = 1'b0;
    endtask

    task automatic wait_if(output int edge_no, output logic [31:0] d);
        edge_no = -1;
        d = 32'hDEAD_BEEF;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (if_done) begin
                edge_no = cyc;
                d = if_din;
                break;
            end
        end
        if_signal = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (mem_a !== 32'h0) begin
            errors++; $display("FAIL reset_mem_a: got %h expected 00000000", mem_a);
        end
        checks++;
        if ({mem_dout, mem_wr} !== 9'h0) begin
            errors++; $display("FAIL reset_mem_dout_wr: got %h/%b expected 00/0", mem_dout, mem_wr);
        end
        checks++;
        if ({lsb_din, if_din, lsb_done, if_done} !== 66'h0) begin
            errors++; $display("FAIL reset_resp: got %h %h %b %b expected zeros", lsb_din, if_din, lsb_done, if_done);
        end
        rst_in = 1'b1;
        // Reset in the middle of a store drops the transfer at once.
        issue(1'b1, 1'b0, 2'b11, 32'h0000_03F0, 32'h7777_7777);
        @(negedge clk);
        @(negedge clk);
        rst_in = 1'b0;
        lsb_signal = 1'b0;
        #1;
        checks++;
        if (mem_wr !== 1'b0) begin
            errors++; $display("FAIL reset_mid_wr: got %b expected 0", mem_wr);
        end
        checks++;
        if (mem_a !== 32'h0) begin
            errors++; $display("FAIL reset_mid_addr: got %h expected 00000000", mem_a);
        end
        @(negedge clk);
        rst_in = 1'b1;
    endtask

    task automatic test_load_word();
        int ed;
        logic [31:0] d;
        wn = 0;
        issue(1'b0, 1'b1, 2'b11, 32'h0000_0100, 32'h0);
        wait_lsb(ed, d);
        checks++;
        if (d !== 32'h1234_5678) begin
            errors++; $display("FAIL load_word_data: got %h expected 12345678", d);
        end
        checks++;
        if (ed - e0 !== 5) begin
            errors++; $display("FAIL load_word_latency: got %0d expected 5", ed - e0);
        end
        @(negedge clk);
        checks++;
        if (lsb_done !== 1'b0) begin
            errors++; $display("FAIL load_word_done_width: got %b expected 0", lsb_done);
        end
        checks++;
        if (wn !== 0) begin
            errors++; $display("FAIL load_word_no_write: got %0d writes expected 0", wn);
        end
    endtask

    task automatic test_load_ext();
        int ed;
        logic [31:0] d;
        issue(1'b0, 1'b1, 2'b00, 32'h0000_0110, 32'h0);
        wait_lsb(ed, d);
        checks++;
        if (d !== 32'hFFFF_FF80 || ed - e0 !== 2) begin
            errors++; $display("FAIL signed_byte: got %h lat %0d expected ffffff80 lat 2", d, ed - e0);
        end
        issue(1'b0, 1'b0, 2'b00, 32'h0000_0110, 32'h0);
        wait_lsb(ed, d);
        checks++;
        if (d !== 32'h0000_0080) begin
            errors++; $display("FAIL unsigned_byte: got %h expected 00000080", d);
        end
        issue(1'b0, 1'b0, 2'b01, 32'h0000_0120, 32'h0);
        wait_lsb(ed, d);
        checks++;
        if (d !== 32'h0000_8001 || ed - e0 !== 3) begin
            errors++; $display("FAIL unsigned_half: got %h lat %0d expected 00008001 lat 3", d, ed - e0);
        end
        issue(1'b0, 1'b1, 2'b01, 32'h0000_0120, 32'h0);
        wait_lsb(ed, d);
        checks++;
        if (d !== 32'hFFFF_8001) begin
            errors++; $display("FAIL signed_half: got %h expected ffff8001", d);
        end
        issue(1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'h0);
        wait_lsb(ed, d);
        checks++;
        if (d !== 32'h1234_5678 || ed - e0 !== 5) begin
            errors++; $display("FAIL len10_word: got %h lat %0d expected 12345678 lat 5", d, ed - e0);
        end
    endtask

    task automatic test_store();
        int ed;
        logic [31:0] d;
        logic [7:0] exp_b [0:3];
        exp_b[0] = 8'hDD; exp_b[1] = 8'hCC; exp_b[2] = 8'hBB; exp_b[3] = 8'hAA;
        wn = 0;
        issue(1'b1, 1'b0, 2'b11, 32'h0000_0200, 32'hAABB_CCDD);
        wait_lsb(ed, d);
        checks++;
        if (ed - e0 !== 4) begin
            errors++; $display("FAIL store_latency: got %0d expected 4", ed - e0);
        end
        checks++;
        if (wn !== 4) begin
            errors++; $display("FAIL store_count: got %0d expected 4", wn);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wa[i] !== 32'h0000_0200 + 32'(i) || wd[i] !== exp_b[i]) begin
                errors++; $display("FAIL store_byte%0d: got %h@%h expected %h@%h", i, wd[i], wa[i], exp_b[i], 32'h200 + 32'(i));
            end
        end
        checks++;
        if (wc[3] - wc[0] !== 3) begin
            errors++; $display("FAIL store_consecutive: got span %0d expected 3", wc[3] - wc[0]);
        end
        checks++;
        if (mem_wr !== 1'b0) begin
            errors++; $display("FAIL store_wr_low: got %b expected 0", mem_wr);
        end
    endtask

    task automatic test_priority();
        int ed_l, ed_i;
        logic [31:0] d_l, d_i;
        @(negedge clk);
        lsb_wr = 1'b0; lsb_signed = 1'b1; lsb_len = 2'b11; lsb_addr = 32'h0000_0100;
        lsb_signal = 1'b1;
        if_addr = 32'h0000_0140;
        if_signal = 1'b1;
        e0 = cyc + 1;
        wait_lsb(ed_l, d_l);
        checks++;
        if (d_l !== 32'h1234_5678 || ed_l - e0 !== 5) begin
            errors++; $display("FAIL prio_lsb_first: got %h lat %0d expected 12345678 lat 5", d_l, ed_l - e0);
        end
        checks++;
        if (if_done !== 1'b0) begin
            errors++; $display("FAIL prio_if_not_yet: got %b expected 0", if_done);
        end
        wait_if(ed_i, d_i);
        checks++;
        if (ed_i - ed_l !== 7) begin
            errors++; $display("FAIL prio_if_latency: got %0d expected 7", ed_i - ed_l);
        end
        checks++;
        if (d_i !== 32'h0000_0513) begin
            errors++; $display("FAIL prio_if_data: got %h expected 00000513", d_i);
        end
    endtask

    task automatic test_clear_read();
        int ed;
        logic [31:0] d;
        int seen;
        issue(1'b0, 1'b1, 2'b11, 32'h0000_0100, 32'h0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        clear_signal = 1'b1;
        lsb_signal = 1'b0;
        @(negedge clk);
        clear_signal = 1'b0;
        checks++;
        if (mem_a !== 32'h0000_0102) begin
            errors++; $display("FAIL clear_read_addr: got %h expected 00000102", mem_a);
        end
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (lsb_done) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL clear_read_no_done: got %0d pulses expected 0", seen);
        end
        issue(1'b0, 1'b1, 2'b00, 32'h0000_0110, 32'h0);
        wait_lsb(ed, d);
        checks++;
        if (d !== 32'hFFFF_FF80 || ed - e0 !== 2) begin
            errors++; $display("FAIL clear_read_recover: got %h lat %0d expected ffffff80 lat 2", d, ed - e0);
        end
    endtask

    task automatic test_clear_write();
        int ed;
        logic [31:0] d;
        wn = 0;
        issue(1'b1, 1'b0, 2'b11, 32'h0000_0210, 32'h1122_3344);
        @(negedge clk);
        clear_signal = 1'b1;
        @(negedge clk);
        clear_signal = 1'b0;
        wait_lsb(ed, d);
        checks++;
        if (ed - e0 !== 4) begin
            errors++; $display("FAIL clear_write_latency: got %0d expected 4", ed - e0);
        end
        checks++;
        if (wn !== 4) begin
            errors++; $display("FAIL clear_write_count: got %0d expected 4", wn);
        end
        checks++;
        if (wa[3] !== 32'h0000_0213 || wd[3] !== 8'h11) begin
            errors++; $display("FAIL clear_write_last: got %h@%h expected 11@00000213", wd[3], wa[3]);
        end
        checks++;
        if (ram[12'h210] !== 8'h44 || ram[12'h212] !== 8'h22) begin
            errors++; $display("FAIL clear_write_ram: got %h %h expected 44 22", ram[12'h210], ram[12'h212]);
        end
    endtask

    task automatic test_io_stall();
        int ed;
        logic [31:0] d;
        wn = 0;
        io_buffer_full = 1'b1;
        issue(1'b1, 1'b0, 2'b00, 32'h0003_0000, 32'h0000_005A);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (mem_wr !== 1'b0) begin
                errors++; $display("FAIL io_stall_wr%0d: got %b expected 0", k, mem_wr);
            end
        end
        io_buffer_full = 1'b0;
        #1;
        checks++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h0003_0000) begin
            errors++; $display("FAIL io_resume: got %b@%h expected 1@00030000", mem_wr, mem_a);
        end
        wait_lsb(ed, d);
        checks++;
        if (ed - e0 !== 4) begin
            errors++; $display("FAIL io_latency: got %0d expected 4", ed - e0);
        end
        checks++;
        if (wn !== 1 || wd[0] !== 8'h5A) begin
            errors++; $display("FAIL io_single_write: got %0d writes byte %h expected 1 byte 5a", wn, wd[0]);
        end
    endtask

    task automatic test_rdy_pause();
        int ed;
        logic [31:0] d;
        issue(1'b0, 1'b1, 2'b11, 32'h0000_0100, 32'h0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rdy_in = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_a !== 32'h0000_0102) begin
            errors++; $display("FAIL rdy_frozen_addr: got %h expected 00000102", mem_a);
        end
        @(negedge clk);
        rdy_in = 1'b1;
        wait_lsb(ed, d);
        checks++;
        if (d !== 32'h1234_5678) begin
            errors++; $display("FAIL rdy_data: got %h expected 12345678", d);
        end
        checks++;
        if (ed - e0 !== 7) begin
            errors++; $display("FAIL rdy_latency: got %0d expected 7", ed - e0);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h78; ram[12'h101] = 8'h56; ram[12'h102] = 8'h34; ram[12'h103] = 8'h12;
        ram[12'h110] = 8'h80;
        ram[12'h120] = 8'h01; ram[12'h121] = 8'h80;
        ram[12'h140] = 8'h13; ram[12'h141] = 8'h05; ram[12'h142] = 8'h00; ram[12'h143] = 8'h00;

        test_reset();
        test_load_word();
        test_load_ext();
        test_store();
        test_priority();
        test_clear_read();
        test_clear_write();
        test_io_stall();
        test_rdy_pause();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
